// File: rtl/mcu_reg_file.sv
// mcu_reg_file
//   Register file and 32-bit command FIFO behind the MCU synchronous-memory bus
//   bridge. 16-bit writes to CMD_LO/CMD_HI assemble one 32-bit motion command;
//   the CMD_HI write pushes it. POS_LO/POS_HI provide tear-free position reads.
//
//   Optional feature macro: MCU_REG_IRQ_EN (IRQ_THR register and level irq).
//
// Ports
//   clk       system clock (shared with the bus bridge)
//   aclr_n    asynchronous active-low reset
//   addr      word address from the bridge
//   write     one-cycle write strobe, wrdata valid with it
//   wrdata    write data
//   read      one-cycle strobe per bus read access
//   rddata    combinational read data for addr
//   pos_in    live 32-bit position from the motion generator
//   enable    CTRL.bit0
//   cmd_data  FIFO head word (0 while empty)
//   cmd_valid FIFO not empty
//   cmd_ready consumer accepts the head when cmd_valid && cmd_ready
//   irq       level interrupt (tied 0 without MCU_REG_IRQ_EN)
module mcu_reg_file #(
  parameter int unsigned DEPTH = 16,
  parameter logic [15:0] ID    = 16'hC3A1
) (
  input  logic        clk,
  input  logic        aclr_n,
  input  logic [15:0] addr,
  input  logic        write,
  input  logic [15:0] wrdata,
  input  logic        read,
  output logic [15:0] rddata,
  input  logic [31:0] pos_in,
  output logic        enable,
  output logic [31:0] cmd_data,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic        irq
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [15:0] A_ID      = 16'h0000;
  localparam logic [15:0] A_CTRL    = 16'h0001;
  localparam logic [15:0] A_STATUS  = 16'h0002;
  localparam logic [15:0] A_IRQ_THR = 16'h0003;
  localparam logic [15:0] A_CMD_LO  = 16'h0004;
  localparam logic [15:0] A_CMD_HI  = 16'h0005;
  localparam logic [15:0] A_POS_LO  = 16'h0006;
  localparam logic [15:0] A_POS_HI  = 16'h0007;

  localparam logic [AW:0]   LVL_FULL = DEPTH[AW:0];
  localparam logic [AW:0]   LVL_ONE  = 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;

  logic          en_q;
  logic          ovf_q;
  logic [15:0]   lo_q;
  logic [15:0]   snap_q;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   level;
  logic [31:0]   mem [DEPTH];

  logic empty, full, pop, push_try, flush, push_ok, ovf_set;

  assign empty    = (level == '0);
  assign full     = (level == LVL_FULL);
  assign pop      = !empty && cmd_ready;
  assign push_try = write && (addr == A_CMD_HI);
  assign flush    = write && (addr == A_CTRL) && wrdata[1];
  // A pop in the same cycle frees the slot the push needs; flush drops the push
  // silently (no overflow).
  assign push_ok  = push_try && (!full || pop) && !flush;
  assign ovf_set  = push_try && full && !pop && !flush;

  assign enable    = en_q;
  assign cmd_valid = !empty;
  assign cmd_data  = empty ? '0 : mem[rptr];

  // Storage carries no reset; the head is masked while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= {wrdata, lo_q};
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push_ok) wptr <= wptr + PTR_ONE;
      if (pop)     rptr <= rptr + PTR_ONE;
      if (push_ok && !pop)      level <= level + LVL_ONE;
      else if (!push_ok && pop) level <= level - LVL_ONE;
    end
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      en_q   <= 1'b0;
      ovf_q  <= 1'b0;
      lo_q   <= '0;
      snap_q <= '0;
    end else begin
      if (write && addr == A_CTRL)   en_q <= wrdata[0];
      if (write && addr == A_CMD_LO) lo_q <= wrdata;
      // Set beats the write-1-to-clear in the same cycle.
      if (ovf_set)                                        ovf_q <= 1'b1;
      else if (write && addr == A_STATUS && wrdata[15])   ovf_q <= 1'b0;
      if (read && addr == A_POS_LO) snap_q <= pos_in[31:16];
    end
  end

`ifdef MCU_REG_IRQ_EN
  logic [8:0] thr_q;
  logic       irq_q;

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      thr_q <= '0;
      irq_q <= 1'b0;
    end else begin
      if (write && addr == A_IRQ_THR) thr_q <= wrdata[8:0];
      irq_q <= (9'(level) <= thr_q) && en_q;
    end
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rddata = '0;
    case (addr)
      A_ID:      rddata = ID;
      A_CTRL:    rddata = {15'd0, en_q};
      A_STATUS:  rddata = {ovf_q, empty, full, 4'd0, 9'(level)};
`ifdef MCU_REG_IRQ_EN
      A_IRQ_THR: rddata = {7'd0, thr_q};
`endif
      A_POS_LO:  rddata = pos_in[15:0];
      A_POS_HI:  rddata = snap_q;
      default:   rddata = '0;
    endcase
  end

endmodule

// File: tb/tb_mcu_reg_file.sv
// Self-checking bench for mcu_reg_file: queue-based reference model plus
// directed literal checks, followed by randomized traffic with a mid-run reset.
module tb_mcu_reg_file;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        aclr_n = 1'b0;
  logic [15:0] addr = '0;
  logic        write = 1'b0;
  logic [15:0] wrdata = '0;
  logic        read = 1'b0;
  logic [15:0] rddata;
  logic [31:0] pos_in = '0;
  logic        enable;
  logic [31:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready = 1'b0;
  logic        irq;

  int n_checks = 0;
  int n_pass   = 0;

  mcu_reg_file #(.DEPTH(DEPTH), .ID(16'hC3A1)) dut (
    .clk(clk), .aclr_n(aclr_n), .addr(addr), .write(write), .wrdata(wrdata),
    .read(read), .rddata(rddata), .pos_in(pos_in), .enable(enable),
    .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] q[$];
  logic        m_en, m_ovf, m_irq;
  logic [8:0]  m_thr;
  logic [15:0] m_lo, m_snap;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [15:0] exp_rd(input logic [15:0] a);
    int lvl;
    lvl = q.size();
    case (a)
      16'h0000: return 16'hC3A1;
      16'h0001: return {15'd0, m_en};
      16'h0002: return {m_ovf, lvl == 0, lvl == DEPTH, 4'd0, 9'(lvl)};
      16'h0003: return {7'd0, m_thr};
      16'h0006: return pos_in[15:0];
      16'h0007: return m_snap;
      default:  return 16'h0000;
    endcase
  endfunction

  always @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      q.delete();
      m_en = 0; m_ovf = 0; m_irq = 0; m_thr = '0; m_lo = '0; m_snap = '0;
    end else begin
      bit do_pop, do_flush, push_try, was_full;
      logic irq_next;
      do_pop   = (q.size() != 0) && cmd_ready;
      do_flush = write && addr == 16'h0001 && wrdata[1];
      push_try = write && addr == 16'h0005;
      was_full = (q.size() == DEPTH);
`ifdef MCU_REG_IRQ_EN
      irq_next = (q.size() <= int'(m_thr)) && m_en;
`else
      irq_next = 1'b0;
`endif
      if (do_flush) q.delete();
      else begin
        if (do_pop) void'(q.pop_front());
        if (push_try) begin
          if (!was_full || do_pop) q.push_back({wrdata, m_lo});
          else m_ovf = 1'b1;
        end
      end
      if (write && addr == 16'h0002 && wrdata[15] && !(push_try && was_full && !do_pop && !do_flush))
        m_ovf = 1'b0;
      if (write && addr == 16'h0001) m_en = wrdata[0];
      if (write && addr == 16'h0004) m_lo = wrdata;
`ifdef MCU_REG_IRQ_EN
      if (write && addr == 16'h0003) m_thr = wrdata[8:0];
`endif
      if (read && addr == 16'h0006) m_snap = pos_in[31:16];
      m_irq = irq_next;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (!aclr_n) begin
      check("rst_cmd_valid", cmd_valid, 0);
      check("rst_irq", irq, 0);
    end else begin
      check("rddata", rddata, exp_rd(addr));
      check("cmd_valid", cmd_valid, q.size() != 0);
      check("cmd_data", cmd_data, (q.size() != 0) ? q[0] : 32'd0);
      check("enable", enable, m_en);
      check("irq", irq, m_irq);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    addr = a; write = 1'b1; wrdata = d;
    step();
    write = 1'b0;
  endtask

  task automatic rdchk(input logic [15:0] a, input logic [15:0] exp, input string name);
    addr = a; read = 1'b1;
    @(negedge clk);
    check(name, rddata, exp);
    step();
    read = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rdy_pct;
    pos_in = 32'h0001FFFF;
    repeat (3) step();
    aclr_n = 1'b1;
    step();

    // Reset values (POS_HI before POS_LO so no snapshot is taken first)
    rdchk(16'h0000, 16'hC3A1, "rst_id");
    rdchk(16'h0001, 16'h0000, "rst_ctrl");
    rdchk(16'h0002, 16'h4000, "rst_status");
    rdchk(16'h0003, 16'h0000, "rst_thr");
    rdchk(16'h0004, 16'h0000, "rst_cmdlo");
    rdchk(16'h0005, 16'h0000, "rst_cmdhi");
    rdchk(16'h0007, 16'h0000, "rst_poshi");
    rdchk(16'h0006, 16'hFFFF, "rst_poslo");
    check("rst_valid_lit", cmd_valid, 0);
    check("rst_data_lit", cmd_data, 32'h0);

    // Command assembly
    cmd_ready = 1'b0;
    wr(16'h0004, 16'h1234);
    wr(16'h0005, 16'hABCD);
    @(negedge clk);
    check("asm_valid", cmd_valid, 1);
    check("asm_data", cmd_data, 32'hABCD1234);
    step();
    rdchk(16'h0002, 16'h0001, "asm_status");

    // Overflow
    wr(16'h0001, 16'h0002);
    for (int i = 0; i < 17; i++) wr(16'h0005, 16'(i));
    rdchk(16'h0002, 16'hA010, "ovf_status");
    wr(16'h0002, 16'h8000);
    rdchk(16'h0002, 16'h2010, "ovf_w1c");
    cmd_ready = 1'b1;
    wr(16'h0005, 16'h5A5A);
    cmd_ready = 1'b0;
    rdchk(16'h0002, 16'h2010, "full_push_pop");
    @(negedge clk);
    check("full_pp_head", cmd_data, 32'h00011234);
    step();
    wr(16'h0005, 16'h6666);
    rdchk(16'h0002, 16'hA010, "ovf_again");

    // Flush with level 5: level 0, ovf kept
    wr(16'h0001, 16'h0002);
    rdchk(16'h0002, 16'hC000, "flush_full");
    for (int i = 0; i < 5; i++) wr(16'h0005, 16'(16'h100 + i));
    rdchk(16'h0002, 16'h8005, "lvl5");
    wr(16'h0001, 16'h0002);
    @(negedge clk);
    check("flush_valid", cmd_valid, 0);
    step();
    rdchk(16'h0002, 16'hC000, "flush_status");
    wr(16'h0002, 16'h8000);

    // Ordering under concurrent flow
    for (int i = 0; i < 8; i++) begin
      cmd_ready = i[0];
      wr(16'h0005, 16'(16'h200 + i));
    end
    cmd_ready = 1'b1;
    for (int i = 0; i < 40 && cmd_valid; i++) step();
    cmd_ready = 1'b0;
    check("drain_empty", cmd_valid, 0);
    rdchk(16'h0002, 16'h4000, "drain_status");

    // Tear-free position readback
    pos_in = 32'h0001FFFF;
    rdchk(16'h0006, 16'hFFFF, "pos_lo");
    pos_in = 32'h00020000;
    rdchk(16'h0007, 16'h0001, "pos_hi");

`ifdef MCU_REG_IRQ_EN
    // irq rises one cycle after level reaches threshold
    for (int i = 0; i < 3; i++) wr(16'h0005, 16'(16'h300 + i));
    wr(16'h0003, 16'h0002);
    wr(16'h0001, 16'h0001);
    @(negedge clk);
    check("irq_lvl3", irq, 0);
    step();
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    @(negedge clk);
    check("irq_same_cycle", irq, 0);
    step();
    @(negedge clk);
    check("irq_rise", irq, 1);
    step();
    wr(16'h0001, 16'h0002);
`endif

    // Randomized traffic with a reset in the middle
    for (int c = 0; c < 2000; c++) begin
      int r;
      rdy_pct = (c < 1000) ? 10 : 60;
      if (c == 1500) begin
        aclr_n = 1'b0;
        step();
        step();
        aclr_n = 1'b1;
      end
      r = $urandom_range(0, 9);
      if (r < 4)       addr = 16'h0005;
      else if (r == 9) addr = 16'($urandom);
      else             addr = 16'($urandom_range(0, 7));
      write  = ($urandom_range(0, 1) == 1);
      wrdata = 16'($urandom);
      if (addr == 16'h0001 && $urandom_range(0, 9) != 0) wrdata[1] = 1'b0;
      read      = ($urandom_range(0, 1) == 1);
      cmd_ready = ($urandom_range(0, 99) < rdy_pct);
      pos_in    = $urandom;
      step();
    end
    write = 1'b0; read = 1'b0; cmd_ready = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
